// File: rtl/comb_basics_unit.sv
// ============================================================================
// comb_basics_unit: registered full adder, 3-to-8 decoder and 8-to-3 priority
// encoder with active-low seven-segment output.       Revision: 1.0
// ============================================================================
`default_nettype none

module comb_basics_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_a,
  input  logic       alu_b,
  input  logic       alu_c,
  output logic       alu_s,
  output logic       alu_c_out,
  input  logic [2:0] x,
  input  logic       en,
  output logic [7:0] y_dec,
  input  logic [7:0] ec_x,
  input  logic       ec_en,
  output logic [2:0] ec_y,
  output logic       ec_valid,
  output logic [7:0] ec_seg
);

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  logic       alu_s_d, alu_s_q;
  logic       alu_c_out_d, alu_c_out_q;
  logic [7:0] y_dec_d, y_dec_q;
  logic [2:0] ec_y_d, ec_y_q;
  logic       ec_valid_d, ec_valid_q;
  logic [7:0] ec_seg_d, ec_seg_q;

  always_comb begin
    alu_s_d     = alu_a ^ alu_b ^ alu_c;
    alu_c_out_d = (alu_a & alu_b) | (alu_a & alu_c) | (alu_b & alu_c);
  end

  always_comb begin
    y_dec_d = 8'h00;
    if (en) begin
      y_dec_d = 8'h01 << x;
    end
  end

  // Bit 7 wins; a disabled or empty request vector reports index 0, invalid.
  always_comb begin
    ec_y_d     = 3'd0;
    ec_valid_d = 1'b0;
    if (ec_en) begin
      ec_valid_d = 1'b1;
      casez (ec_x)
        8'b1???????: ec_y_d = 3'd7;
        8'b01??????: ec_y_d = 3'd6;
        8'b001?????: ec_y_d = 3'd5;
        8'b0001????: ec_y_d = 3'd4;
        8'b00001???: ec_y_d = 3'd3;
        8'b000001??: ec_y_d = 3'd2;
        8'b0000001?: ec_y_d = 3'd1;
        8'b00000001: ec_y_d = 3'd0;
        default: begin
          ec_y_d     = 3'd0;
          ec_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Active-low segments, bit0 = a ... bit6 = g, bit7 = dp (kept off).
  always_comb begin
    ec_seg_d = SEG_BLANK;
    if (ec_valid_d) begin
      case (ec_y_d)
        3'd0:    ec_seg_d = 8'hC0;
        3'd1:    ec_seg_d = 8'hF9;
        3'd2:    ec_seg_d = 8'hA4;
        3'd3:    ec_seg_d = 8'hB0;
        3'd4:    ec_seg_d = 8'h99;
        3'd5:    ec_seg_d = 8'h92;
        3'd6:    ec_seg_d = 8'h82;
        default: ec_seg_d = 8'hF8;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_s_q     <= 1'b0;
      alu_c_out_q <= 1'b0;
      y_dec_q     <= 8'h00;
      ec_y_q      <= 3'd0;
      ec_valid_q  <= 1'b0;
      ec_seg_q    <= SEG_BLANK;
    end else begin
      alu_s_q     <= alu_s_d;
      alu_c_out_q <= alu_c_out_d;
      y_dec_q     <= y_dec_d;
      ec_y_q      <= ec_y_d;
      ec_valid_q  <= ec_valid_d;
      ec_seg_q    <= ec_seg_d;
    end
  end

  assign alu_s     = alu_s_q;
  assign alu_c_out = alu_c_out_q;
  assign y_dec     = y_dec_q;
  assign ec_y      = ec_y_q;
  assign ec_valid  = ec_valid_q;
  assign ec_seg    = ec_seg_q;

endmodule

`default_nettype wire

// File: tb/tb_comb_basics_unit.sv
// ============================================================================
// tb_comb_basics_unit: directed and random checks of comb_basics_unit against
// an arithmetic reference model.                      Revision: 1.0
// ============================================================================
`default_nettype none

module tb_comb_basics_unit;

  logic       clk;
  logic       rst;
  logic       alu_a, alu_b, alu_c;
  logic       alu_s, alu_c_out;
  logic [2:0] x;
  logic       en;
  logic [7:0] y_dec;
  logic [7:0] ec_x;
  logic       ec_en;
  logic [2:0] ec_y;
  logic       ec_valid;
  logic [7:0] ec_seg;

  int checks = 0;
  int errors = 0;

  logic       exp_s, exp_c;
  logic [7:0] exp_dec;
  logic [2:0] exp_y;
  logic       exp_v;
  logic [7:0] exp_seg;

  logic [7:0] seg_tab [8];

  comb_basics_unit dut (
    .clk       (clk),
    .rst       (rst),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .alu_s     (alu_s),
    .alu_c_out (alu_c_out),
    .x         (x),
    .en        (en),
    .y_dec     (y_dec),
    .ec_x      (ec_x),
    .ec_en     (ec_en),
    .ec_y      (ec_y),
    .ec_valid  (ec_valid),
    .ec_seg    (ec_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: sum/carry from the arithmetic total, decoder as a power of two,
  // encoder as a scan keeping the highest set index.
  task automatic model();
    int total;
    total   = int'(alu_a) + int'(alu_b) + int'(alu_c);
    exp_s   = logic'(total % 2);
    exp_c   = logic'(total / 2);
    exp_dec = en ? 8'(2 ** int'(x)) : 8'h00;
    exp_y   = 3'd0;
    exp_v   = 1'b0;
    if (ec_en) begin
      for (int i = 0; i < 8; i++) begin
        if (ec_x[i]) begin
          exp_y = 3'(i);
          exp_v = 1'b1;
        end
      end
    end
    exp_seg = exp_v ? seg_tab[exp_y] : 8'hFF;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".s"},     {7'd0, alu_s},     {7'd0, exp_s});
    chk({tag, ".cout"},  {7'd0, alu_c_out}, {7'd0, exp_c});
    chk({tag, ".dec"},   y_dec,             exp_dec);
    chk({tag, ".ec_y"},  {5'd0, ec_y},      {5'd0, exp_y});
    chk({tag, ".valid"}, {7'd0, ec_valid},  {7'd0, exp_v});
    chk({tag, ".seg"},   ec_seg,            exp_seg);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".s"},     {7'd0, alu_s},     8'h00);
    chk({tag, ".cout"},  {7'd0, alu_c_out}, 8'h00);
    chk({tag, ".dec"},   y_dec,             8'h00);
    chk({tag, ".ec_y"},  {5'd0, ec_y},      8'h00);
    chk({tag, ".valid"}, {7'd0, ec_valid},  8'h00);
    chk({tag, ".seg"},   ec_seg,            8'hFF);
  endtask

  // Apply one input set, then check the registered result just after the next edge.
  task automatic drive(input string tag, input logic [2:0] abc, input logic [2:0] xi,
                       input logic eni, input logic [7:0] ecxi, input logic eceni);
    {alu_a, alu_b, alu_c} = abc;
    x     = xi;
    en    = eni;
    ec_x  = ecxi;
    ec_en = eceni;
    model();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    rst = 1'b0;
    {alu_a, alu_b, alu_c} = 3'b000;
    x = 3'd0; en = 1'b0; ec_x = 8'h00; ec_en = 1'b0;

    #2 rst = 1'b1;
    #1 chk_reset("reset_init");
    @(posedge clk);
    #1 chk_reset("reset_held");
    #2 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive($sformatf("adder_%0d", i), 3'(i), 3'd0, 1'b0, 8'h00, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      drive($sformatf("dec_%0d", i), 3'b000, 3'(i), 1'b1, 8'h00, 1'b0);
    end
    drive("dec_off", 3'b000, 3'd5, 1'b0, 8'h00, 1'b0);

    drive("enc_29", 3'b000, 3'd0, 1'b0, 8'b0010_1001, 1'b1);
    chk("enc_29.lit_y", {5'd0, ec_y}, 8'd5);
    chk("enc_29.lit_seg", ec_seg, 8'h92);
    drive("enc_80", 3'b000, 3'd0, 1'b0, 8'h80, 1'b1);
    chk("enc_80.lit_seg", ec_seg, 8'hF8);
    drive("enc_01", 3'b000, 3'd0, 1'b0, 8'h01, 1'b1);
    chk("enc_01.lit_seg", ec_seg, 8'hC0);
    drive("enc_zero", 3'b000, 3'd0, 1'b0, 8'h00, 1'b1);
    drive("enc_dis", 3'b000, 3'd0, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive($sformatf("enc_bit%0d", i), 3'b000, 3'd0, 1'b0, 8'h01 << i, 1'b1);
    end

    // Mid-cycle asynchronous reset with non-reset outputs present.
    drive("pre_rst", 3'b111, 3'd3, 1'b1, 8'h44, 1'b1);
    {alu_a, alu_b, alu_c} = 3'b110;
    x = 3'd6; en = 1'b1; ec_x = 8'h12; ec_en = 1'b1;
    #3 rst = 1'b1;
    #1 chk_reset("rst_async");
    @(posedge clk);
    #1 chk_reset("rst_discard");
    #2 rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive($sformatf("pipe_%0d", i), 3'($urandom), 3'($urandom), 1'($urandom),
            8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/comb_basics_unit.md
# comb_basics_unit

Registered wrapper around three small combinational primitives: a 1-bit full adder, a 3-to-8 decoder with enable, and an 8-to-3 priority encoder with enable, valid flag and seven-segment digit output. All outputs are captured in flops on one clock, so the block can sit on the board-level top next to LEDs and segment displays.

## Interface
Parameters:
- none. All widths are fixed.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_a  in  1  adder operand A.
- alu_b  in  1  adder operand B.
- alu_c  in  1  adder carry-in.
- alu_s  out  1  registered sum.
- alu_c_out  out  1  registered carry-out.
- x  in  3  decoder select.
- en  in  1  decoder enable.
- y_dec  out  8  registered one-hot decoder output.
- ec_x  in  8  encoder request vector.
- ec_en  in  1  encoder enable.
- ec_y  out  3  registered index of the highest set request bit.
- ec_valid  out  1  registered; 1 when enabled and at least one request bit is set.
- ec_seg  out  8  registered active-low seven-segment pattern of ec_y. Bit0 = a … bit6 = g, bit7 = dp.

## Operation
Adder:
- sum = a ^ b ^ c.
- carry = (a&b) | (a&c) | (b&c).

Decoder:
- en=1: y_dec = 8'b1 << x.
- en=0: y_dec = 8'h00.

Encoder:
- ec_en=1 and ec_x≠0: ec_y = index of the most significant 1 in ec_x (bit 7 has highest priority); ec_valid=1.
- ec_en=0, or ec_x=0: ec_y=0 and ec_valid=0.

Segment output:
- ec_valid=1: ec_seg shows ec_y using these codes: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8 (hex, dp off).
- ec_valid=0: ec_seg = FF (blank).

Inputs and state:
- All inputs are sampled together on each clock edge.
- The block has no internal state other than the output registers.
- No X propagation: every input combination maps to a defined output.

## Timing
- Latency is exactly 1 cycle. Outputs at edge N+1 reflect the inputs sampled at edge N.
- Throughput is one new input set per cycle. There is no handshake.
- While rst=1, outputs immediately and asynchronously take these values:
  - alu_s=0, alu_c_out=0
  - y_dec=00
  - ec_y=0, ec_valid=0
  - ec_seg=FF
- Releasing rst: the first capture happens on the first rising clk edge after rst falls.
- Reset asserted mid-stream: outputs clear immediately, and any pending result is discarded.
- Simultaneous changes on every input group are independent. The three paths never interact.

## Test plan
- Reset: assert rst asynchronously mid-cycle with arbitrary outputs present. All outputs go to their reset values before the next edge: y_dec=00, ec_seg=FF, all others 0.
- Adder exhaustive: drive all 8 combinations of (a,b,c). One cycle later:
  - (0,0,0) → s=0, c_out=0
  - (1,1,0) → s=0, c_out=1
  - (1,0,0) → s=1, c_out=0
  - (1,1,1) → s=1, c_out=1
- Decoder:
  - en=1, x=0..7 → y_dec = 01, 02, 04 … 80 on the following cycle.
  - en=0, x=5 → y_dec=00.
- Encoder priority:
  - ec_en=1, ec_x=8'b0010_1001 → ec_y=5, ec_valid=1, ec_seg=92.
  - ec_x=80 → ec_y=7, ec_seg=F8.
  - ec_x=01 → ec_y=0, ec_valid=1, ec_seg=C0.
- Encoder idle:
  - ec_en=1, ec_x=00 → ec_y=0, ec_valid=0, ec_seg=FF.
  - ec_en=0, ec_x=FF → same outputs as above.
- Pipelining: change all inputs every cycle for 20 random cycles. Each output must equal the reference function of the inputs from the previous cycle, with no bubbles.
